// File: rtl/ctrl_delay_chain_pkg.sv
// Shared constants and helpers for control delay chains.
// Sized for the vector execute control path by default.
package pipe_pkg;

  localparam int VEC_CTRL_DEPTH = 9;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ctrl_delay_chain_if.sv
// Valid/ready word stream between pipeline units.
// Master drives valid/data, slave drives ready.
interface ctrl_delay_chain_if #(
  parameter int WIDTH = 64
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/ctrl_chain_stage.sv
// One valid/data slot of the delay chain.
// Loads upstream on load, otherwise holds its surviving word.
module ctrl_chain_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             kill,
  input  logic             in_v,
  input  logic [WIDTH-1:0] in_d,
  output logic             v,
  output logic             ev,
  output logic             v_nxt,
  output logic [WIDTH-1:0] d
);

  assign ev    = v & ~kill;
  assign v_nxt = load ? in_v : ev;

  // slot register; data only changes on an actual load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= 1'b0;
      d <= '0;
    end else begin
      v <= v_nxt;
      if (load && in_v) d <= in_d;
    end
  end

endmodule

// File: rtl/ctrl_delay_chain.sv
// Elastic control delay line with kill, flush, stall,
// bubble collapse, per-stage taps and occupancy count.
module ctrl_delay_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = VEC_CTRL_DEPTH,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ctrl_delay_chain_if.slave      in_if,
  ctrl_delay_chain_if.master     out_if,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [DEPTH-1:0]       kill_mask,
  output logic [DEPTH-1:0]       tap_valid,
  output logic [DEPTH*WIDTH-1:0] tap_data,
  output logic [CNT_W-1:0]       occupancy,
  output logic                   empty
);

  logic [DEPTH-1:0] ev;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] v_nxt;
  logic             accept;
  logic [CNT_W-1:0] cnt_nxt;

  assign in_if.ready  = rdy[0] & ~flush;
  assign accept       = in_if.valid & in_if.ready;
  assign out_if.valid = ev[DEPTH-1] & ~stall;
  assign out_if.data  = tap_data[(DEPTH-1)*WIDTH +: WIDTH];
  assign empty        = (occupancy == '0);

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      logic             up_v;
      logic [WIDTH-1:0] up_d;

      // a slot can take a word if any slot at or above it is
      // free, or the whole upper run drains into writeback
      if (g == DEPTH-1) begin : g_last
        assign rdy[g] = ~stall & (~ev[g] | out_if.ready);
      end else begin : g_mid
        assign rdy[g] = ~stall
                      & (~(&ev[DEPTH-1:g]) | out_if.ready);
      end

      if (g == 0) begin : g_head
        assign up_v = accept;
        assign up_d = in_if.data;
      end else begin : g_body
        assign up_v = ev[g-1];
        assign up_d = tap_data[(g-1)*WIDTH +: WIDTH];
      end

      ctrl_chain_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (rdy[g]),
        .kill  (kill_mask[g] | flush),
        .in_v  (up_v),
        .in_d  (up_d),
        .v     (tap_valid[g]),
        .ev    (ev[g]),
        .v_nxt (v_nxt[g]),
        .d     (tap_data[g*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // population count of next-cycle valids
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + CNT_W'(v_nxt[i]);
  end

  // occupancy register tracks popcount of the valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occupancy <= '0;
    else        occupancy <= cnt_nxt;
  end

endmodule

// File: tb/tb_ctrl_delay_chain.sv
// Randomised and directed bench for ctrl_delay_chain.
// Reference: slot array compacted toward the output each cycle.
module tb_ctrl_delay_chain;

  localparam int D = 9;
  localparam int W = 64;
  localparam int CW = $clog2(D + 1);

  logic           clk;
  logic           rst_n;
  logic           stall;
  logic           flush;
  logic [D-1:0]   kill_mask;
  logic [D-1:0]   tap_valid;
  logic [D*W-1:0] tap_data;
  logic [CW-1:0]  occupancy;
  logic           empty;

  ctrl_delay_chain_if #(.WIDTH(W)) in_if ();
  ctrl_delay_chain_if #(.WIDTH(W)) out_if ();

  ctrl_delay_chain #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_if     (in_if),
    .out_if    (out_if),
    .stall     (stall),
    .flush     (flush),
    .kill_mask (kill_mask),
    .tap_valid (tap_valid),
    .tap_data  (tap_data),
    .occupancy (occupancy),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  bit          mv [D];
  logic [63:0] md [D];
  logic [63:0] acc_log [$];
  logic [63:0] out_log [$];
  int          cyc;
  int          first_acc;
  int          first_ov;
  bit          last_acc;
  logic [63:0] next_word;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] tap(input int i);
    return tap_data[i*W +: W];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < D; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
  endtask

  task automatic cycle();
    bit          nv [D];
    logic [63:0] nd [D];
    bit          e_ir;
    bit          e_ov;
    logic [63:0] e_od;
    logic [D-1:0] e_tv;
    int          cnt;
    @(negedge clk);
    cnt = 0;
    for (int i = 0; i < D; i++) begin
      nv[i] = mv[i] && !kill_mask[i] && !flush;
      nd[i] = md[i];
      e_tv[i] = mv[i];
      cnt += int'(mv[i]);
    end
    e_ov = nv[D-1] && !stall;
    e_od = nd[D-1];
    if (!stall) begin
      if (nv[D-1] && out_if.ready) nv[D-1] = 1'b0;
      for (int i = D-2; i >= 0; i--)
        if (nv[i] && !nv[i+1]) begin
          nv[i+1] = 1'b1;
          nd[i+1] = nd[i];
          nv[i]   = 1'b0;
        end
    end
    e_ir = !stall && !flush && !nv[0];
    last_acc = e_ir && in_if.valid;
    if (last_acc) begin
      nv[0] = 1'b1;
      nd[0] = in_if.data;
      acc_log.push_back(in_if.data);
      if (first_acc < 0) first_acc = cyc;
    end
    chk("in_ready", 64'(in_if.ready), 64'(e_ir));
    chk("out_valid", 64'(out_if.valid), 64'(e_ov));
    if (e_ov) begin
      chk("out_data", out_if.data, e_od);
      if (first_ov < 0) first_ov = cyc;
      if (out_if.ready) out_log.push_back(e_od);
    end
    chk("occupancy", 64'(occupancy), 64'(cnt));
    chk("empty", 64'(empty), 64'(cnt == 0));
    chk("tap_valid", 64'(tap_valid), 64'(e_tv));
    for (int i = 0; i < D; i++)
      if (mv[i]) chk($sformatf("tap_data%0d", i), tap(i), md[i]);
    @(posedge clk);
    #1;
    for (int i = 0; i < D; i++) begin
      mv[i] = nv[i];
      md[i] = nd[i];
    end
    cyc++;
    if (last_acc) next_word++;
    in_if.data = next_word;
  endtask

  task automatic idle_in();
    in_if.valid   = 1'b0;
    out_if.ready  = 1'b1;
    stall         = 1'b0;
    flush         = 1'b0;
    kill_mask     = '0;
  endtask

  task automatic drain(input int n);
    idle_in();
    repeat (n) cycle();
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ov"}, 64'(out_if.valid), 64'd0);
    chk({tag, "_od"}, out_if.data, 64'd0);
    chk({tag, "_tv"}, 64'(tap_valid), 64'd0);
    chk({tag, "_td"}, 64'(|tap_data), 64'd0);
    chk({tag, "_occ"}, 64'(occupancy), 64'd0);
    chk({tag, "_empty"}, 64'(empty), 64'd1);
    chk({tag, "_ir"}, 64'(in_if.ready), 64'd1);
  endtask

  task automatic check_logs(input string tag, input logic [63:0] base);
    chk({tag, "_count"}, 64'(out_log.size()), 64'(acc_log.size()));
    for (int i = 0; i < out_log.size() && i < acc_log.size(); i++) begin
      chk({tag, "_order"}, out_log[i], acc_log[i]);
      chk({tag, "_seq"}, out_log[i], base + 64'(i));
    end
  endtask

  logic [D-1:0]   sv_tv;
  logic [D*W-1:0] sv_td;
  logic [63:0]    k2;
  logic [63:0]    k4;
  int             hit;

  initial begin
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    first_acc = -1;
    first_ov = -1;
    next_word = 64'd1;
    rst_n = 1'b0;
    idle_in();
    in_if.data = next_word;
    model_clear();
    #12;
    check_reset_outs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // stream 1..20
    acc_log.delete();
    out_log.delete();
    in_if.valid = 1'b1;
    while (next_word <= 64'd20 && cyc < 200) begin
      in_if.valid = 1'b1;
      cycle();
      if (occupancy == CW'(D)) hit = 1;
    end
    chk("stream_full_occ", 64'(hit), 64'd1);
    drain(12);
    chk("latency", 64'(first_ov - first_acc), 64'(D));
    check_logs("stream", 64'd1);

    // fill with backpressure
    acc_log.delete();
    out_log.delete();
    next_word = 64'd100;
    in_if.data = next_word;
    out_if.ready = 1'b0;
    in_if.valid = 1'b1;
    repeat (12) cycle();
    chk("fill_occ", 64'(occupancy), 64'(D));
    chk("fill_in_ready", 64'(in_if.ready), 64'd0);
    out_if.ready = 1'b1;
    cycle();
    chk("full_pass_acc", 64'(last_acc), 64'd1);
    chk("full_pass_occ", 64'(occupancy), 64'(D));
    drain(12);
    check_logs("fill", 64'd100);

    // bubble collapse
    out_if.ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_if.valid = (i == 0 || i == 2 || i == 4);
      in_if.data  = 64'hA + 64'(i / 2);
      cycle();
    end
    chk("bubble_tv", 64'(tap_valid), 64'h1C0);
    chk("bubble_A", tap(8), 64'hA);
    chk("bubble_B", tap(7), 64'hB);
    chk("bubble_C", tap(6), 64'hC);
    drain(12);

    // stall mid-stream
    acc_log.delete();
    out_log.delete();
    next_word = 64'd200;
    in_if.data = next_word;
    in_if.valid = 1'b1;
    repeat (6) cycle();
    sv_tv = tap_valid;
    sv_td = tap_data;
    stall = 1'b1;
    repeat (3) begin
      cycle();
      chk("stall_tv", 64'(tap_valid), 64'(sv_tv));
      chk("stall_td", 64'(tap_data == sv_td), 64'd1);
    end
    stall = 1'b0;
    repeat (6) cycle();
    drain(12);
    check_logs("stall", 64'd200);

    // selective kill while advancing
    out_log.delete();
    next_word = 64'd300;
    in_if.data = next_word;
    in_if.valid = 1'b1;
    repeat (D) cycle();
    chk("kill_pre_occ", 64'(occupancy), 64'(D));
    k2 = md[2];
    k4 = md[4];
    kill_mask = 9'b000010100;
    cycle();
    kill_mask = '0;
    chk("kill_occ", 64'(occupancy), 64'(D - 2));
    drain(14);
    hit = 0;
    foreach (out_log[i])
      if (out_log[i] == k2 || out_log[i] == k4) hit++;
    chk("kill_gone", 64'(hit), 64'd0);
    chk("kill_survivors", 64'(out_log.size()), 64'(D - 1));

    // flush with stall and valid input
    in_if.valid = 1'b1;
    repeat (4) cycle();
    flush = 1'b1;
    stall = 1'b1;
    cycle();
    chk("flush_acc", 64'(last_acc), 64'd0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    flush = 1'b0;
    stall = 1'b0;

    // reset with words in flight
    out_if.ready = 1'b0;
    in_if.valid = 1'b1;
    repeat (5) cycle();
    chk("prerst_occ", 64'(occupancy), 64'd5);
    in_if.valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outs("midrst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      in_if.valid  = $urandom_range(0, 3) != 0;
      in_if.data   = {$urandom, $urandom};
      out_if.ready = $urandom_range(0, 3) != 0;
      stall        = $urandom_range(0, 9) == 0;
      flush        = $urandom_range(0, 39) == 0;
      kill_mask    = ($urandom_range(0, 7) == 0) ? D'($urandom) : '0;
      cycle();
    end
    drain(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
